// File: rtl/time_stamp_recorder.sv
// Parking-slot time stamp recorder: prescaled clock, per-slot entry stamps, exit stamp pairs.
// Optional overstay tracking enabled by defining TIME_STAMP_RECORDER_OVERSTAY_EN.
module time_stamp_recorder #(
    parameter int SLOTS    = 8,
    parameter int SW       = 3,
    parameter int TW       = 8,
    parameter int TICK_DIV = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             entry_req,
    input  logic [SW-1:0]    entry_slot,
    input  logic             exit_req,
    input  logic [SW-1:0]    exit_slot,
    output logic [TW-1:0]    time_now,
    output logic [TW-1:0]    time_in,
    output logic [TW-1:0]    time_out,
    output logic [SW-1:0]    stamp_slot,
    output logic             stamp_valid,
    output logic [SLOTS-1:0] occupied,
    output logic             err,
    output logic             stamp_ovf
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]    r_presc;
    logic [TW-1:0]    r_time;
    logic [TW-1:0]    r_stamp [SLOTS];
    logic [SLOTS-1:0] r_occ;
    logic [TW-1:0]    r_time_in;
    logic [TW-1:0]    r_time_out;
    logic [SW-1:0]    r_slot;
    logic             r_valid;
    logic             r_err;

    logic [SLOTS-1:0] w_ent_hit;
    logic [SLOTS-1:0] w_ext_hit;
    logic [TW-1:0]    w_ext_stamp;
    logic [TW-1:0]    w_time_nxt;
    logic             w_tick;
    logic             w_ext_ok;
    logic             w_ent_ok;
    logic             w_err;

    assign w_tick     = (r_presc == PW'(TICK_DIV - 1));
    assign w_time_nxt = r_time + 1'b1;

    // Out-of-range indices match no slot, so they fall out as illegal.
    always_comb begin
        w_ext_stamp = '0;
        for (int i = 0; i < SLOTS; i++) begin
            w_ent_hit[i] = entry_req && (entry_slot == SW'(i));
            w_ext_hit[i] = exit_req && (exit_slot == SW'(i));
            if (w_ext_hit[i]) w_ext_stamp = r_stamp[i];
        end
    end

    assign w_ext_ok = |(w_ext_hit & r_occ);
    // A same-slot exit frees the slot for the entry in the same edge.
    assign w_ent_ok = |(w_ent_hit & (~r_occ | w_ext_hit));
    assign w_err    = (entry_req && !w_ent_ok) || (exit_req && !w_ext_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc    <= '0;
            r_time     <= '0;
            r_occ      <= '0;
            r_time_in  <= '0;
            r_time_out <= '0;
            r_slot     <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            for (int i = 0; i < SLOTS; i++) r_stamp[i] <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) r_time <= w_time_nxt;
            r_valid <= w_ext_ok;
            r_err   <= w_err;
            if (w_ext_ok) begin
                r_time_in  <= w_ext_stamp;
                r_time_out <= r_time;
                r_slot     <= exit_slot;
            end
            for (int i = 0; i < SLOTS; i++) begin
                if (w_ext_hit[i] && r_occ[i]) r_occ[i] <= 1'b0;
                if (w_ent_hit[i] && w_ent_ok) begin
                    r_occ[i]   <= 1'b1;
                    r_stamp[i] <= r_time;
                end
            end
        end
    end

`ifdef TIME_STAMP_RECORDER_OVERSTAY_EN
    logic [SLOTS-1:0] r_ovf;
    logic             r_stamp_ovf;
    logic             w_ext_ovf;

    assign w_ext_ovf = |(w_ext_hit & r_ovf);

    // The counter catching up to a stored stamp means the dwell aliased.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf       <= '0;
            r_stamp_ovf <= 1'b0;
        end else begin
            if (w_ext_ok) r_stamp_ovf <= w_ext_ovf;
            for (int i = 0; i < SLOTS; i++) begin
                if (w_ent_hit[i] && w_ent_ok)
                    r_ovf[i] <= 1'b0;
                else if (w_tick && r_occ[i] && (r_stamp[i] == w_time_nxt))
                    r_ovf[i] <= 1'b1;
            end
        end
    end

    assign stamp_ovf = r_stamp_ovf;
`else
    assign stamp_ovf = 1'b0;
`endif

    assign time_now    = r_time;
    assign time_in     = r_time_in;
    assign time_out    = r_time_out;
    assign stamp_slot  = r_slot;
    assign stamp_valid = r_valid;
    assign occupied    = r_occ;
    assign err         = r_err;

endmodule

// File: tb/tb_time_stamp_recorder.sv
// Bench for time_stamp_recorder: vector table, directed corners, random vs. absolute-time model.
// Expects stamp_ovf activity only when TIME_STAMP_RECORDER_OVERSTAY_EN is defined.
module tb_time_stamp_recorder;

    localparam int SLOTS = 8;
    localparam int SW    = 3;
    localparam int TW    = 8;
    localparam int TD    = 4;
    localparam int MOD   = 256;
`ifdef TIME_STAMP_RECORDER_OVERSTAY_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             entry_req, exit_req;
    logic [SW-1:0]    entry_slot, exit_slot;
    logic [TW-1:0]    time_now, time_in, time_out;
    logic [SW-1:0]    stamp_slot;
    logic             stamp_valid, err, stamp_ovf;
    logic [SLOTS-1:0] occupied;

    time_stamp_recorder #(
        .SLOTS(SLOTS), .SW(SW), .TW(TW), .TICK_DIV(TD)
    ) dut (
        .clk(clk), .rst(rst),
        .entry_req(entry_req), .entry_slot(entry_slot),
        .exit_req(exit_req), .exit_slot(exit_slot),
        .time_now(time_now), .time_in(time_in), .time_out(time_out),
        .stamp_slot(stamp_slot), .stamp_valid(stamp_valid),
        .occupied(occupied), .err(err), .stamp_ovf(stamp_ovf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: absolute cycle count and absolute entry time in units.
    int m_cyc;
    bit m_occ [SLOTS];
    int m_ent [SLOTS];
    int e_tin, e_tout, e_slot;
    bit e_valid, e_err, e_ovf;

    typedef struct {
        bit en; int es; bit ex; int xs;
        bit v; bit er; int occ; int tin;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", n, act, exp);
        end
    endtask

    function automatic int occ_mask();
        int m = 0;
        for (int i = 0; i < SLOTS; i++) if (m_occ[i]) m |= (1 << i);
        return m;
    endfunction

    task automatic compare_all();
        chk("time_now", time_now, (m_cyc / TD) % MOD);
        chk("stamp_valid", stamp_valid, e_valid);
        chk("err", err, e_err);
        chk("occupied", occupied, occ_mask());
        chk("time_in", time_in, e_tin);
        chk("time_out", time_out, e_tout);
        chk("stamp_slot", stamp_slot, e_slot);
        chk("stamp_ovf", stamp_ovf, e_ovf);
    endtask

    task automatic cyc(input bit en, input int es, input bit ex, input int xs);
        int u;
        bit xok, eok;
        entry_req  = en;
        entry_slot = SW'(es);
        exit_req   = ex;
        exit_slot  = SW'(xs);
        u   = m_cyc / TD;
        xok = ex && m_occ[xs];
        eok = en && (!m_occ[es] || (xok && xs == es));
        e_err   = (en && !eok) || (ex && !xok);
        e_valid = xok;
        if (xok) begin
            e_tin  = m_ent[xs] % MOD;
            e_tout = u % MOD;
            e_slot = xs;
            e_ovf  = OVF_EN && ((u - m_ent[xs]) >= MOD);
            m_occ[xs] = 1'b0;
        end
        if (eok) begin
            m_occ[es] = 1'b1;
            m_ent[es] = u;
        end
        m_cyc++;
        @(posedge clk);
        #1;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        compare_all();
    endtask

    task automatic do_reset(input bit with_req);
        rst        = 1'b1;
        entry_req  = with_req;
        exit_req   = with_req;
        entry_slot = '0;
        exit_slot  = '0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        m_cyc = 0;
        for (int i = 0; i < SLOTS; i++) begin
            m_occ[i] = 1'b0;
            m_ent[i] = 0;
        end
        e_tin = 0; e_tout = 0; e_slot = 0;
        e_valid = 0; e_err = 0; e_ovf = 0;
        compare_all();
    endtask

    task automatic idle_to(input int t);
        for (int k = 0; k < 2000; k++) begin
            if ((m_cyc / TD) % MOD == t) break;
            cyc(0, 0, 0, 0);
        end
        chk("reach_time", time_now, t);
    endtask

    initial begin
        tbl[0]  = '{0,0,1,3, 0,1,8'h00,0};
        tbl[1]  = '{1,0,0,0, 0,0,8'h01,0};
        tbl[2]  = '{0,0,0,0, 0,0,8'h01,0};
        tbl[3]  = '{0,0,0,0, 0,0,8'h01,0};
        tbl[4]  = '{0,0,0,0, 0,0,8'h01,0};
        tbl[5]  = '{0,0,0,0, 0,0,8'h01,0};
        tbl[6]  = '{1,0,0,0, 0,1,8'h01,0};
        tbl[7]  = '{1,5,1,0, 1,0,8'h20,0};
        tbl[8]  = '{0,0,0,0, 0,0,8'h20,0};
        tbl[9]  = '{1,5,1,5, 1,0,8'h20,1};
        tbl[10] = '{1,1,1,2, 0,1,8'h22,0};
        tbl[11] = '{1,1,1,3, 0,1,8'h22,0};

        rst = 1'b1; entry_req = 0; exit_req = 0;
        entry_slot = '0; exit_slot = '0;

        // Prescaler: three ticks in twelve cycles
        do_reset(0);
        repeat (12) cyc(0, 0, 0, 0);
        chk("tick_time3", time_now, 3);

        // Basic dwell
        do_reset(0);
        idle_to(5);
        cyc(1, 2, 0, 0);
        idle_to(17);
        cyc(0, 0, 1, 2);
        chk("p1_valid", stamp_valid, 1);
        chk("p1_tin", time_in, 5);
        chk("p1_tout", time_out, 17);
        chk("p1_slot", stamp_slot, 2);
        chk("p1_occ2", occupied[2], 0);
        chk("p1_diff", 8'(time_out - time_in), 12);
        cyc(0, 0, 0, 0);
        chk("p1_pulse_end", stamp_valid, 0);
        chk("p1_hold_tin", time_in, 5);

        // Counter wrap between entry and exit
        do_reset(0);
        idle_to(250);
        cyc(1, 1, 0, 0);
        idle_to(4);
        cyc(0, 0, 1, 1);
        chk("wrap_tin", time_in, 250);
        chk("wrap_tout", time_out, 4);
        chk("wrap_diff", 8'(time_out - time_in), 10);

        // Table of illegal / simultaneous requests
        do_reset(0);
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].en, tbl[i].es, tbl[i].ex, tbl[i].xs);
            chk("tbl_valid", stamp_valid, tbl[i].v);
            chk("tbl_err", err, tbl[i].er);
            chk("tbl_occ", occupied, tbl[i].occ);
            if (tbl[i].v) chk("tbl_tin", time_in, tbl[i].tin);
        end

        // Same-slot exit+entry re-stamps
        do_reset(0);
        idle_to(7);
        cyc(1, 4, 0, 0);
        idle_to(20);
        cyc(1, 4, 1, 4);
        chk("same_valid", stamp_valid, 1);
        chk("same_tin", time_in, 7);
        chk("same_tout", time_out, 20);
        chk("same_occ4", occupied[4], 1);
        chk("same_err", err, 0);
        idle_to(25);
        cyc(0, 0, 1, 4);
        chk("restamp_tin", time_in, 20);
        chk("restamp_tout", time_out, 25);

        // Long overstay
        do_reset(0);
        idle_to(10);
        cyc(1, 0, 0, 0);
        repeat (260 * TD) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        chk("ovs_tin", time_in, 10);
        chk("ovs_tout", time_out, 14);
        chk("ovs_flag", stamp_ovf, OVF_EN);

        // Dwell of 255 vs 256 units
        do_reset(0);
        idle_to(2);
        cyc(1, 3, 0, 0);
        cyc(1, 5, 0, 0);
        idle_to(1);
        cyc(0, 0, 1, 5);
        chk("dwell255_ovf", stamp_ovf, 0);
        idle_to(2);
        cyc(0, 0, 1, 3);
        chk("dwell256_ovf", stamp_ovf, OVF_EN);

        // Reset mid-operation with requests in the reset cycle
        cyc(1, 6, 0, 0);
        cyc(1, 7, 0, 0);
        do_reset(1);
        chk("rst_occ", occupied, 0);
        cyc(0, 0, 1, 6);
        chk("rst_no_stamp", stamp_valid, 0);

        // Random traffic against the model
        do_reset(0);
        for (int n = 0; n < 6000; n++) begin
            int es, xs;
            es = $urandom_range(0, SLOTS - 1);
            xs = ($urandom_range(0, 3) == 0) ? es : $urandom_range(0, SLOTS - 1);
            cyc($urandom_range(0, 15) == 0, es, $urandom_range(0, 15) == 0, xs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
